// File: rtl/fir_pkg.sv
// Shared state type and arithmetic helpers for the serial FIR MAC.
// Build option FIR_SAT_EN selects output saturation instead of two's-complement wrap.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        FLUSH
    } fir_state_t;

    function automatic int acc_width(input int wl, input int cwl, input int taps);
        return wl + cwl + $clog2(taps);
    endfunction

    // Fits a sign-extended value into owl bits; the result comes back sign-extended to 64.
    function automatic logic signed [63:0] fit_out(input logic signed [63:0] v, input int owl);
`ifdef FIR_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (owl - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (owl - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        return (v <<< (64 - owl)) >>> (64 - owl);
`endif
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Runtime-loadable coefficient registers with one write port and a combinational read.
// A same-cycle write and read of one index returns the old value.
module fir_coef_bank #(
    parameter int CWL  = 8,
    parameter int TAPS = 16,
    localparam int KW  = $clog2(TAPS)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  we,
    input  logic [KW-1:0]         waddr,
    input  logic signed [CWL-1:0] wdata,
    input  logic [KW-1:0]         raddr,
    output logic signed [CWL-1:0] rdata
);

    logic signed [CWL-1:0] coef [TAPS];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < TAPS; i++) coef[i] <= '0;
        end else if (we) begin
            coef[waddr] <= wdata;
        end
    end

    assign rdata = coef[raddr];

endmodule

// File: rtl/fir_mac_serial.sv
// Time-multiplexed FIR: one registered multiplier iterated over TAPS coefficients per sample.
// Output scaling saturates when FIR_SAT_EN is defined, otherwise wraps.
//
//   state | meaning
//   IDLE  | ready for a sample; accept writes history, clears acc and k
//   MAC   | one tap per cycle: product <= x[wr_ptr-k]*h[k], acc += previous product
//   FLUSH | fold in last product, emit scaled result, advance write pointer
module fir_mac_serial
    import fir_pkg::*;
#(
    parameter int WL    = 8,
    parameter int CWL   = 8,
    parameter int TAPS  = 16,
    parameter int OWL   = 16,
    parameter int SHIFT = 0,
    localparam int KW   = $clog2(TAPS)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [WL-1:0]  in,
    input  logic                  coef_we,
    input  logic [KW-1:0]         coef_addr,
    input  logic signed [CWL-1:0] coef_data,
    output logic                  out_valid,
    output logic signed [OWL-1:0] out
);

    localparam int AW = acc_width(WL, CWL, TAPS);
    localparam int PW = WL + CWL;

    fir_state_t state, state_nxt;

    logic [KW-1:0]         wr_ptr;
    logic [KW-1:0]         k;
    logic [KW-1:0]         rd_idx;
    logic signed [WL-1:0]  hist [TAPS];
    logic signed [WL-1:0]  x_rd;
    logic signed [CWL-1:0] h_rd;
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  acc_sum;
    logic signed [AW-1:0]  acc_sh;
    logic signed [OWL-1:0] fit_val;

    fir_coef_bank #(
        .CWL  (CWL),
        .TAPS (TAPS)
    ) u_coef_bank (
        .CLK   (CLK),
        .RST   (RST),
        .we    (coef_we),
        .waddr (coef_addr),
        .wdata (coef_data),
        .raddr (k),
        .rdata (h_rd)
    );

    // Pointer subtraction wraps naturally because TAPS is a power of two.
    assign rd_idx  = wr_ptr - k;
    assign x_rd    = hist[rd_idx];
    assign acc_sum = acc + {{(AW-PW){prod[PW-1]}}, prod};
    assign acc_sh  = acc_sum >>> SHIFT;
    assign fit_val = OWL'(fit_out({{(64-AW){acc_sh[AW-1]}}, acc_sh}, OWL));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = MAC;
            end
            MAC:     if (k == KW'(TAPS - 1)) state_nxt = FLUSH;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < TAPS; i++) hist[i] <= '0;
            wr_ptr    <= '0;
            k         <= '0;
            acc       <= '0;
            prod      <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        hist[wr_ptr] <= in;
                        k            <= '0;
                        acc          <= '0;
                    end
                end
                MAC: begin
                    prod <= PW'(x_rd) * PW'(h_rd);
                    k    <= k + KW'(1);
                    // The first MAC cycle has no earlier product to fold in.
                    if (k != '0) acc <= acc_sum;
                end
                FLUSH: begin
                    out       <= fit_val;
                    out_valid <= 1'b1;
                    wr_ptr    <= wr_ptr + KW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_serial.sv
// Scoreboard bench for fir_mac_serial: a behavioural FIR model predicts every result at accept time.
// Expected values follow FIR_SAT_EN so the bench matches either build.
module tb_fir_mac_serial;

    localparam int TAPS = 16;
    localparam int WL   = 8;
    localparam int CWL  = 8;
    localparam int OWL  = 16;
    localparam int KW   = $clog2(TAPS);

    logic                  CLK = 1'b0;
    logic                  RST;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [WL-1:0]  x;
    logic                  coef_we;
    logic [KW-1:0]         coef_addr;
    logic signed [CWL-1:0] coef_data;
    logic                  out_valid;
    logic signed [OWL-1:0] y;

    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;
    int     n_out    = 0;
    int     last_acc = 0;
    int     acc_t [4];
    int     n_before;
    longint sb_q [$];
    int     lat_q [$];
    longint mh [TAPS];
    longint mhist [TAPS];
    int     mw;

    fir_mac_serial dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (x),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out       (y)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic longint scale(input longint v);
        longint r;
`ifdef FIR_SAT_EN
        if (v > 32767) r = 32767;
        else if (v < -32768) r = -32768;
        else r = v;
`else
        r = v & 64'hFFFF;
        if (r >= 32768) r = r - 65536;
`endif
        return r;
    endfunction

    function automatic longint model_push(input longint s);
        longint acc;
        acc = 0;
        mhist[mw] = s;
        for (int k = 0; k < TAPS; k++) acc += mh[k] * mhist[(mw - k + TAPS) % TAPS];
        mw = (mw + 1) % TAPS;
        return scale(acc);
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < TAPS; k++) begin
            mh[k]    = 0;
            mhist[k] = 0;
        end
        mw = 0;
    endfunction

    always @(negedge CLK) begin
        if (out_valid === 1'b1) begin
            n_out++;
            if (sb_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                chk("out", y, sb_q.pop_front());
                chk("ready_with_out", in_ready, 1);
                if (lat_q.size() > 0) chk("latency", cyc - lat_q.pop_front(), TAPS + 1);
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 just after the accept edge.
    task automatic send(input longint s, input bit hold);
        int t;
        t = 0;
        x = WL'(s);
        in_valid = 1'b1;
        @(negedge CLK);
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge CLK);
            t++;
        end
        if (in_ready !== 1'b1) begin
            chk("send_timeout", 0, 1);
        end else begin
            last_acc = cyc + 1;
            lat_q.push_back(cyc + 1);
            sb_q.push_back(model_push(s));
        end
        @(posedge CLK);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wr_coef(input int k, input longint v);
        coef_we   = 1'b1;
        coef_addr = KW'(k);
        coef_data = CWL'(v);
        @(posedge CLK);
        #1;
        coef_we = 1'b0;
        mh[k] = v;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 400) begin
            @(posedge CLK);
            t++;
        end
        repeat (2) @(posedge CLK);
        #1;
        chk("drain", sb_q.size(), 0);
    endtask

    initial begin
        RST = 1'b1; in_valid = 1'b0; x = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        model_clear();
        #12;
        chk("rst_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", y, 0);
        @(negedge CLK) RST = 1'b0;
        @(posedge CLK);
        #1;

        // impulse response
        for (int k = 0; k < TAPS; k++) wr_coef(k, k + 1);
        send(1, 0);
        for (int i = 0; i < TAPS; i++) send(0, 0);
        drain();
        chk("impulse_tail", y, 0);

        // continuous in_valid: throughput
        for (int i = 0; i < 4; i++) begin
            send(i * 3 - 5, 1);
            acc_t[i] = last_acc;
        end
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) chk("throughput", acc_t[i] - acc_t[i-1], TAPS + 2);
        drain();

        // overflow, positive then negative
        for (int k = 0; k < TAPS; k++) wr_coef(k, -128);
        for (int i = 0; i < TAPS; i++) send(-128, 0);
        drain();
`ifdef FIR_SAT_EN
        chk("ovf_pos", y, 32767);
`else
        chk("ovf_pos", y, 0);
`endif
        for (int k = 0; k < TAPS; k++) wr_coef(k, 127);
        for (int i = 0; i < TAPS; i++) send(-128, 0);
        drain();
`ifdef FIR_SAT_EN
        chk("ovf_neg", y, -32768);
`else
        chk("ovf_neg", y, 2048);
`endif

        // pointer wrap-around
        for (int k = 0; k < TAPS; k++) wr_coef(k, (k == 0) ? 1 : 0);
        for (int i = 1; i <= 20; i++) send(i, 0);
        drain();
        chk("wrap_tap0", y, 20);
        wr_coef(0, 0);
        wr_coef(15, 1);
        for (int i = 21; i <= 40; i++) send(i, 0);
        drain();
        chk("wrap_tap15", y, 25);

        // coefficient writes during MAC at k=3
        for (int k = 0; k < TAPS; k++) wr_coef(k, 0);
        wr_coef(0, 2);
        mh[15] = 5;
        send(3, 0);
        repeat (3) @(posedge CLK);
        #1;
        wr_coef(15, 5);
        drain();
        send(-7, 0);
        repeat (3) @(posedge CLK);
        #1;
        wr_coef(0, 5);
        drain();
        send(4, 0);
        drain();

        // reset at MAC k=7
        wr_coef(3, 7);
        send(9, 0);
        repeat (7) @(posedge CLK);
        #1;
        n_before = n_out;
        RST = 1'b1;
        #1;
        chk("rst_mid_ready", in_ready, 1);
        chk("rst_mid_out_valid", out_valid, 0);
        sb_q.delete();
        lat_q.delete();
        model_clear();
        @(negedge CLK) RST = 1'b0;
        repeat (TAPS + 4) @(posedge CLK);
        #1;
        chk("rst_no_pulse", n_out - n_before, 0);
        for (int k = 0; k < TAPS; k++) wr_coef(k, k + 1);
        send(1, 0);
        for (int i = 0; i < TAPS; i++) send(0, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fir_mac_serial.md
Name: fir_mac_serial

Overview:
- Time-multiplexed FIR stage directly downstream of the SRL delay-line stage in the filter chain.
- Accepts one aligned sample per handshake and stores it in a TAPS-deep circular history.
- Computes y[n] = sum over k of h[k]*x[n-k] using one registered multiplier iterated over all taps, then emits one scaled result with a valid pulse.
- Coefficients are runtime-loadable through a simple write port.

Parameters:
- WL, 8, sample width (signed two's complement).
- CWL, 8, coefficient width (signed).
- TAPS, 16, number of taps; power of two, minimum 2.
- OWL, 16, output width (signed).
- SHIFT, 0, arithmetic right shift applied to the accumulator before output.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present on `in`.
- in_ready  out  1  block can accept a sample; equals (state==IDLE).
- in  in  WL  signed input sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(TAPS)  tap index k.
- coef_data  in  CWL  signed coefficient h[k].
- out_valid  out  1  single-cycle pulse marking a valid `out`.
- out  out  OWL  signed filter result; held until the next result.

Behaviour:
- Interface: one clock CLK; RST is asynchronous and active-high.
- Reset clears the following: history buffer all 0, coefficients all 0, write pointer 0, accumulator 0, product register 0, out=0, out_valid=0, state=IDLE. in_ready is 1 while RST is high and immediately after it.
- Accumulator width is AW = WL+CWL+clog2(TAPS). It is signed and sized so that it cannot overflow.
- Product register width is WL+CWL, sign-extended into the accumulator.
- State machine: IDLE, MAC, FLUSH.
  - IDLE: on in_valid && in_ready (edge E0), write `in` at wr_ptr; set k=0; clear acc; go to MAC.
  - MAC: each cycle, read x at (wr_ptr - k) mod TAPS and h[k]. The product register is loaded at edge E(k+1). acc += previous product from edge E2 onward. After k=TAPS-1, go to FLUSH.
  - FLUSH (edge E(TAPS+1)): out <= scale(acc + last product); out_valid <= 1; wr_ptr <= wr_ptr+1 mod TAPS; go to IDLE.
- Timing:
  - out_valid is high for exactly one cycle, TAPS+1 cycles after the accept edge.
  - in_ready is high in that same cycle.
  - Sustained throughput is one sample per TAPS+2 cycles.
- in_valid is ignored outside IDLE; the upstream stage holds the sample until accepted.
- scale(): arithmetic shift right by SHIFT, then keep the low OWL bits (two's-complement wrap).
- Coefficient writes are accepted in any state.
  - A write takes effect from the next cycle.
  - During MAC, a write affects the result only if tap k has not yet been read.
  - A write and a read of the same k in the same cycle uses the old value.
- Simultaneous sample accept and coefficient write are both performed.
- RST asserted mid-MAC or mid-FLUSH aborts the computation with no out_valid pulse; history and coefficients return to 0.

Optional Feature:
- Macro: FIR_SAT_EN.
- Defined: after the shift, a value above 2^(OWL-1)-1 clamps to 2^(OWL-1)-1, and a value below -2^(OWL-1) clamps to -2^(OWL-1).
- Undefined: plain two's-complement truncation to OWL bits.
- Latency is identical in both builds.

Decomposition:
- Package fir_pkg holds:
  - the state enum (IDLE, MAC, FLUSH);
  - the accumulator-width function acc_width(WL,CWL,TAPS);
  - the saturate/truncate helper function.
- One sub-module is natural: fir_coef_bank. It holds TAPS x CWL reset-to-zero registers, has a write port, and provides a combinational read by index.

Test Plan:
- Impulse response: load h[k]=k+1, send sample 1 then 16 zeros -> outputs 1,2,...,16 then 0.
- Latency and throughput: hold in_valid=1 continuously -> out_valid pulses at accept+17 cycles, next accept exactly 18 cycles after the previous one, in_ready low for 17 cycles each time.
- Overflow: all h=-128, feed sixteen samples of -128 -> accumulator 262144; out=0 without FIR_SAT_EN, out=32767 with it. Same test with h=+127 and x=-128 -> -260096; out wraps to 2048 without the macro, saturates to -32768 with it.
- Wrap-around: h[0]=1, h[1..15]=0 with samples 1..20 -> out equals each current sample. Then h[15]=1 only -> out equals the sample fifteen positions earlier, correct across the pointer wrap.
- Reset mid-operation: assert RST at MAC k=7 -> no out_valid; in_ready=1 immediately; next impulse with h reloaded gives a clean response with no stale history.
- Coefficient write during MAC: write h[15]=5 while k=3 -> new value used; write h[0]=5 while k=3 -> old value used for this output, new value used for the next.
